// File: rtl/fosfor_present_sequencer.sv
// -----------------------------------------------------------------------------
// fosfor_present_sequencer
//   Nibble-bus front end and round sequencer for the PRESENT-80 datapath.
//   Bytes are assembled from two 4-bit bus writes into a staging register.
//   Bus commands latch a register-file address, write the staging byte, or
//   start/abort an encryption run. A run is sequenced as load, ROUNDS round
//   cycles, then final whitening. The registered byte output returns either
//   register-file read data or the status byte.
//
// Ports
//   Clk_k        in   clock
//   Reset_r      in   synchronous, active-high reset
//   Address_b    in   bus phase: 0 IDLE, 1 LOW, 2 HIGH, 3 CMD
//   DataIn_b     in   bus nibble (data, or command code during CMD)
//   DataOut_b    out  registered read data / status {cnt, error, done, ready}
//   RegAddr_b    out  register-file address (latched address)
//   RegWrData_b  out  register-file write data (staging byte)
//   RegWe        out  register-file write strobe, 1-cycle pulse
//   RegRdData_b  in   register-file read data, combinational from RegAddr_b
//   LoadState    out  copy plaintext/key registers into datapath, pulse
//   RoundEn      out  advance datapath one round
//   RoundCnt_b   out  current round counter, 1..ROUNDS
//   FinalEn      out  final AddRoundKey and cipher store, pulse
// -----------------------------------------------------------------------------
module fosfor_present_sequencer #(
   parameter int unsigned ROUNDS     = 31,
   parameter int unsigned KEY_OFFSET = 8,
   parameter int unsigned REG_AW     = 5
) (
   input  logic              Clk_k,
   input  logic              Reset_r,
   input  logic [1:0]        Address_b,
   input  logic [3:0]        DataIn_b,
   output logic [7:0]        DataOut_b,
   output logic [REG_AW-1:0] RegAddr_b,
   output logic [7:0]        RegWrData_b,
   output logic              RegWe,
   input  logic [7:0]        RegRdData_b,
   output logic              LoadState,
   output logic              RoundEn,
   output logic [4:0]        RoundCnt_b,
   output logic              FinalEn
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ROUND, ST_FINAL} state_t;
   typedef enum logic [1:0] {BUS_IDLE, BUS_LOW, BUS_HIGH, BUS_CMD} bus_t;
   typedef enum logic [3:0] {
      CMD_LATCH   = 4'd1,
      CMD_WRITE   = 4'd2,
      CMD_START   = 4'd3,
      CMD_ABORT   = 4'd4,
      CMD_CLR_ERR = 4'd5
   } cmd_t;

   // Plaintext occupies 0..KEY_OFFSET-1, key the ten bytes after it.
   localparam logic [REG_AW:0] KEY_BASE   = (REG_AW+1)'(KEY_OFFSET);
   localparam logic [REG_AW:0] ADDR_END   = (REG_AW+1)'(KEY_OFFSET + 10);
   localparam logic [4:0]      LAST_ROUND = 5'(ROUNDS);

   state_t            state_q;
   logic [7:0]        staging_q;
   logic [REG_AW-1:0] addr_q;
   logic [7:0]        dout_q;
   logic [4:0]        cnt_q;
   logic              we_q;
   logic              load_q;
   logic              round_q;
   logic              final_q;
   logic              done_q;
   logic              error_q;
   logic              idle_seen_q;

   logic       busy;
   logic       cmd_latch;
   logic       cmd_write;
   logic       cmd_start;
   logic       cmd_abort;
   logic       cmd_clr;
   logic       addr_bad;
   logic       addr_plain;
   logic [7:0] status;

   always_comb begin
      busy       = (state_q != ST_IDLE);
      cmd_latch  = (Address_b == BUS_CMD) && (DataIn_b == CMD_LATCH);
      cmd_write  = (Address_b == BUS_CMD) && (DataIn_b == CMD_WRITE);
      cmd_start  = (Address_b == BUS_CMD) && (DataIn_b == CMD_START);
      cmd_abort  = (Address_b == BUS_CMD) && (DataIn_b == CMD_ABORT);
      cmd_clr    = (Address_b == BUS_CMD) && (DataIn_b == CMD_CLR_ERR);
      addr_bad   = ({1'b0, addr_q} >= ADDR_END);
      addr_plain = ({1'b0, addr_q} < KEY_BASE);
      status     = {cnt_q, error_q, done_q, ~busy};
   end

   always_ff @(posedge Clk_k) begin
      if (Reset_r) begin
         state_q     <= ST_IDLE;
         staging_q   <= '0;
         addr_q      <= '0;
         dout_q      <= 8'h01;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         load_q      <= 1'b0;
         round_q     <= 1'b0;
         final_q     <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         idle_seen_q <= 1'b0;
      end else begin
         we_q        <= 1'b0;
         load_q      <= 1'b0;
         round_q     <= 1'b0;
         final_q     <= 1'b0;
         idle_seen_q <= (Address_b == BUS_IDLE);

         case (Address_b)
            BUS_LOW: begin
               staging_q[3:0] <= DataIn_b;
               dout_q         <= RegRdData_b;
            end
            BUS_HIGH: staging_q[7:4] <= DataIn_b;
            BUS_IDLE: if (idle_seen_q) dout_q <= status;
            default: ;
         endcase

         if (cmd_latch) addr_q <= staging_q[REG_AW-1:0];
         if (cmd_clr) error_q <= 1'b0;

         // Writes are refused during a run so key/plaintext stay stable.
         if (cmd_write) begin
            if (busy || addr_bad) begin
               error_q <= 1'b1;
            end else begin
               we_q <= 1'b1;
               if (addr_plain) done_q <= 1'b0;
            end
         end

         if (cmd_start && busy) error_q <= 1'b1;

         if (cmd_abort && busy) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (cmd_start) begin
                     state_q <= ST_LOAD;
                     load_q  <= 1'b1;
                     done_q  <= 1'b0;
                     cnt_q   <= 5'd1;
                  end
               end
               ST_LOAD: begin
                  state_q <= ST_ROUND;
                  round_q <= 1'b1;
               end
               ST_ROUND: begin
                  if (cnt_q == LAST_ROUND) begin
                     state_q <= ST_FINAL;
                     final_q <= 1'b1;
                  end else begin
                     cnt_q   <= cnt_q + 5'd1;
                     round_q <= 1'b1;
                  end
               end
               // done is set on leaving FINAL so an abort there leaves it clear.
               ST_FINAL: begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign DataOut_b   = dout_q;
   assign RegAddr_b   = addr_q;
   assign RegWrData_b = staging_q;
   assign RegWe       = we_q;
   assign LoadState   = load_q;
   assign RoundEn     = round_q;
   assign RoundCnt_b  = cnt_q;
   assign FinalEn     = final_q;

endmodule

// File: tb/tb_fosfor_present_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fosfor_present_sequencer
//   Directed scenarios plus randomized bus traffic. A behavioural model tracks
//   the run as "edges since START" and derives strobes, round count and status
//   arithmetically; every output is compared after each clock edge.
// -----------------------------------------------------------------------------
module tb_fosfor_present_sequencer;

   localparam int ROUNDS     = 31;
   localparam int KEY_OFFSET = 8;

   logic       Clk_k = 1'b0;
   logic       Reset_r = 1'b1;
   logic [1:0] Address_b = 2'd0;
   logic [3:0] DataIn_b = 4'd0;
   logic [7:0] DataOut_b;
   logic [4:0] RegAddr_b;
   logic [7:0] RegWrData_b;
   logic       RegWe;
   logic [7:0] RegRdData_b;
   logic       LoadState;
   logic       RoundEn;
   logic [4:0] RoundCnt_b;
   logic       FinalEn;

   logic [7:0] rd_salt = 8'h5A;

   int n_checks = 0;
   int n_fail   = 0;

   fosfor_present_sequencer #(
      .ROUNDS(31),
      .KEY_OFFSET(8),
      .REG_AW(5)
   ) dut (
      .Clk_k(Clk_k),
      .Reset_r(Reset_r),
      .Address_b(Address_b),
      .DataIn_b(DataIn_b),
      .DataOut_b(DataOut_b),
      .RegAddr_b(RegAddr_b),
      .RegWrData_b(RegWrData_b),
      .RegWe(RegWe),
      .RegRdData_b(RegRdData_b),
      .LoadState(LoadState),
      .RoundEn(RoundEn),
      .RoundCnt_b(RoundCnt_b),
      .FinalEn(FinalEn)
   );

   // Stand-in register file: read data is a salted function of the address.
   assign RegRdData_b = {3'b000, RegAddr_b} ^ rd_salt;

   always #5 Clk_k = ~Clk_k;

   // Model state
   logic [7:0] m_stage, m_dout;
   logic [4:0] m_addr, m_cnt;
   bit         m_run, m_done, m_err, m_idle_prev, m_we;
   int         m_t;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit rst, input logic [1:0] a, input logic [3:0] d,
                             input logic [7:0] rd);
      bit         busy, start, abort;
      logic [7:0] status;
      if (rst) begin
         m_stage = '0; m_addr = '0; m_cnt = '0; m_dout = 8'h01;
         m_run = 0; m_t = 0; m_done = 0; m_err = 0; m_idle_prev = 0; m_we = 0;
         return;
      end
      busy   = m_run;
      status = {m_cnt, m_err, m_done, ~busy};
      start  = 0;
      abort  = 0;
      m_we   = 0;
      case (a)
         2'd0: if (m_idle_prev) m_dout = status;
         2'd1: begin m_stage[3:0] = d; m_dout = rd; end
         2'd2: m_stage[7:4] = d;
         default: begin
            case (d)
               4'd1: m_addr = m_stage[4:0];
               4'd2: begin
                  if (busy || int'(m_addr) >= KEY_OFFSET + 10) m_err = 1;
                  else begin
                     m_we = 1;
                     if (int'(m_addr) < KEY_OFFSET) m_done = 0;
                  end
               end
               4'd3: if (busy) m_err = 1; else start = 1;
               4'd4: abort = busy;
               4'd5: m_err = 0;
               default: ;
            endcase
         end
      endcase
      m_idle_prev = (a == 2'd0);
      if (abort) begin
         m_run = 0;
      end else if (m_run) begin
         m_t++;
         if (m_t > ROUNDS + 1) begin
            m_run  = 0;
            m_done = 1;
         end else begin
            m_cnt = 5'((m_t < ROUNDS) ? m_t : ROUNDS);
         end
      end else if (start) begin
         m_run = 1; m_t = 0; m_done = 0; m_cnt = 5'd1;
      end
   endtask

   task automatic compare_all();
      check_val("DataOut",   32'(DataOut_b),   32'(m_dout));
      check_val("RegAddr",   32'(RegAddr_b),   32'(m_addr));
      check_val("RegWrData", 32'(RegWrData_b), 32'(m_stage));
      check_val("RegWe",     32'(RegWe),       32'(m_we));
      check_val("LoadState", 32'(LoadState),   32'(m_run && m_t == 0));
      check_val("RoundEn",   32'(RoundEn),     32'(m_run && m_t >= 1 && m_t <= ROUNDS));
      check_val("FinalEn",   32'(FinalEn),     32'(m_run && m_t == ROUNDS + 1));
      check_val("RoundCnt",  32'(RoundCnt_b),  32'(m_cnt));
   endtask

   task automatic cyc(input bit rst, input logic [1:0] a, input logic [3:0] d);
      logic [7:0] rd;
      Reset_r   = rst;
      Address_b = a;
      DataIn_b  = d;
      rd        = {3'b000, m_addr} ^ rd_salt;
      @(posedge Clk_k);
      model_step(rst, a, d, rd);
      #1;
      compare_all();
   endtask

   task automatic put_byte(input logic [7:0] b);
      cyc(0, 2'd1, b[3:0]);
      cyc(0, 2'd2, b[7:4]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 2'd0, 4'd0);
   endtask

   int n_round, n_load, n_final;

   initial begin
      // 1: reset and status after two IDLE samples
      cyc(1, 2'd0, 4'd0);
      cyc(1, 2'd0, 4'd0);
      idle(2);
      check_val("reset_status", 32'(DataOut_b), 32'h01);
      check_val("reset_strobes", 32'({RegWe, LoadState, RoundEn, FinalEn}), 32'h0);

      // 2: latch address 9, write 0xC3
      put_byte(8'h09);
      cyc(0, 2'd3, 4'd1);
      put_byte(8'hC3);
      cyc(0, 2'd3, 4'd2);
      check_val("write_we",   32'(RegWe),       32'h1);
      check_val("write_addr", 32'(RegAddr_b),   32'h09);
      check_val("write_data", 32'(RegWrData_b), 32'hC3);
      idle(1);
      check_val("write_pulse_len", 32'(RegWe), 32'h0);

      // 3: full run
      n_round = 0; n_load = 0; n_final = 0;
      cyc(0, 2'd3, 4'd3);
      n_load += int'(LoadState);
      for (int i = 0; i < 36; i++) begin
         cyc(0, 2'd0, 4'd0);
         n_round += int'(RoundEn);
         n_load  += int'(LoadState);
         n_final += int'(FinalEn);
      end
      check_val("run_rounds", 32'(n_round), 32'd31);
      check_val("run_loads",  32'(n_load),  32'd1);
      check_val("run_finals", 32'(n_final), 32'd1);
      check_val("run_status", 32'(DataOut_b), 32'hFB);

      // 4: START while busy sets error, run still completes
      cyc(0, 2'd3, 4'd3);
      for (int i = 0; i < 40 && m_t != 10; i++) idle(1);
      cyc(0, 2'd3, 4'd3);
      idle(36);
      check_val("busy_start_status", 32'(DataOut_b), 32'hFF);
      cyc(0, 2'd3, 4'd5);
      idle(2);
      check_val("clr_err_status", 32'(DataOut_b), 32'hFB);

      // 5: abort at round 5
      cyc(0, 2'd3, 4'd3);
      for (int i = 0; i < 40 && m_t != 5; i++) idle(1);
      cyc(0, 2'd3, 4'd4);
      check_val("abort_roundEn", 32'(RoundEn), 32'h0);
      check_val("abort_finalEn", 32'(FinalEn), 32'h0);
      idle(2);
      check_val("abort_status", 32'(DataOut_b), 32'h29);

      // 6: out-of-range write, then reset mid-run
      put_byte(8'h1F);
      cyc(0, 2'd3, 4'd1);
      cyc(0, 2'd3, 4'd2);
      check_val("oor_we", 32'(RegWe), 32'h0);
      idle(2);
      check_val("oor_error", 32'(DataOut_b[2]), 32'h1);
      cyc(0, 2'd3, 4'd3);
      idle(8);
      cyc(1, 2'd0, 4'd0);
      check_val("rst_roundEn", 32'(RoundEn), 32'h0);
      idle(2);
      check_val("rst_status", 32'(DataOut_b), 32'h01);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         int unsigned r;
         logic [1:0]  a;
         logic [3:0]  d;
         r = $urandom_range(0, 99);
         if (r < 45)      a = 2'd0;
         else if (r < 65) a = 2'd1;
         else if (r < 80) a = 2'd2;
         else             a = 2'd3;
         d = (a == 2'd3) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0) rd_salt = 8'($urandom);
         cyc($urandom_range(0, 799) == 0, a, d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
